// File: rtl/arp_rx_parser.sv
// -----------------------------------------------------------------------------
// arp_rx_parser
//
// Purpose:
//   Parses the 28-byte ARP payload from a valid/ready/last byte stream carrying
//   DATA_W bits per beat (first stream byte in the most significant lane).
//   Header fields (HTYPE, PTYPE, HLEN, PLEN, OPER) are validated byte by byte
//   as each byte lands. OPER/SHA/SPA/THA/TPA are extracted and presented on a
//   valid/ready result port that is held until accepted. Frames that fail a
//   check produce a one-cycle coded error pulse instead of a result.
//   Bytes beyond offset 27 (Ethernet padding) are ignored.
//
// Parameters:
//   DATA_W       input beat width: 8, 16 or 32
//   ACCEPT_REPLY 1: OPER 2 (reply) is accepted; 0: OPER 2 reports ERR_OPER
//
// Build option:
//   ARP_TPA_FILTER_EN  when defined, a frame whose TPA differs from local_ip
//                      reports ERR_TPA (code 6) and is never presented on
//                      m_valid. When undefined, local_ip is ignored.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   s_valid/s_ready input beat handshake
//   s_data          payload bytes, big-endian lane order
//   s_last          final beat of frame (may carry padding past byte 27)
//   local_ip        own IPv4 address (used only with ARP_TPA_FILTER_EN)
//   m_valid/m_ready parsed-result handshake
//   oper/sha/spa/tha/tpa  parsed fields, stable while m_valid is high
//   err_valid       one-cycle error pulse after the s_last beat
//   err_code        error cause, meaningful with err_valid
//
// Error codes: 0 none, 1 HTYPE, 2 PTYPE, 3 HLEN/PLEN, 4 OPER, 5 truncated,
//              6 TPA mismatch, 7 reserved.
// -----------------------------------------------------------------------------
module arp_rx_parser #(
    parameter int DATA_W       = 8,
    parameter int ACCEPT_REPLY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [31:0]       local_ip,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       oper,
    output logic [47:0]       sha,
    output logic [31:0]       spa,
    output logic [47:0]       tha,
    output logic [31:0]       tpa,
    output logic              err_valid,
    output logic [2:0]        err_code
);

    localparam int BPB = DATA_W / 8;

    localparam logic [5:0] FRAME_BYTES = 6'd28;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HDR   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_HTYPE = 3'd1;
    localparam logic [2:0] ERR_PTYPE = 3'd2;
    localparam logic [2:0] ERR_LEN   = 3'd3;
    localparam logic [2:0] ERR_OPER  = 3'd4;
    localparam logic [2:0] ERR_TRUNC = 3'd5;
`ifdef ARP_TPA_FILTER_EN
    localparam logic [2:0] ERR_TPA   = 3'd6;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [4:0] r_bcnt;          // bytes consumed, saturates at 28
    logic [2:0] r_err;           // first error seen in the current frame
    logic       r_err_pulse;
    logic [2:0] r_err_code;

    // Payload bytes 6..27 (OPER through TPA). HTYPE..PLEN are only checked,
    // never stored.
    logic [7:0] r_fld [6:27];

    // -------------------------------------------------------------------------
    // Per-beat combinational view
    // -------------------------------------------------------------------------
    logic [7:0] w_byte [BPB];
    logic [4:0] w_off  [BPB];    // payload offset of each lane in this beat
    logic       w_take;
    logic       w_collect;
    logic [5:0] w_bcnt_sum;
    logic       w_full_next;
    logic [4:0] w_bcnt_next;
    logic [2:0] w_beat_err;
    logic [2:0] w_frame_err;
    logic [2:0] w_err_now;

    for (genvar g = 0; g < BPB; g++) begin : g_lane
        assign w_byte[g] = s_data[DATA_W-1-8*g -: 8];
        // r_bcnt <= 28 and g <= 3, so the sum always fits in 5 bits.
        assign w_off[g]  = r_bcnt + 5'(g);
    end

    assign s_ready   = (r_state != S_HOLD);
    assign m_valid   = (r_state == S_HOLD);
    assign w_take    = s_valid && s_ready;
    assign w_collect = (r_state == S_IDLE) || (r_state == S_HDR);

    assign w_bcnt_sum  = {1'b0, r_bcnt} + 6'(BPB);
    assign w_full_next = (w_bcnt_sum >= FRAME_BYTES);
    assign w_bcnt_next = w_full_next ? FRAME_BYTES[4:0] : w_bcnt_sum[4:0];

    // Check a single payload byte against the fixed header values. Offsets
    // outside the checked header (8 and up) never raise an error here.
    function automatic logic [2:0] byte_err(input logic [4:0] off,
                                            input logic [7:0] b);
        logic [2:0] code;
        code = ERR_NONE;
        case (off)
            5'd0: if (b != 8'h00) code = ERR_HTYPE;
            5'd1: if (b != 8'h01) code = ERR_HTYPE;
            5'd2: if (b != 8'h08) code = ERR_PTYPE;
            5'd3: if (b != 8'h00) code = ERR_PTYPE;
            5'd4: if (b != 8'h06) code = ERR_LEN;
            5'd5: if (b != 8'h04) code = ERR_LEN;
            5'd6: if (b != 8'h00) code = ERR_OPER;
            5'd7: if (!((b == 8'h01) || ((b == 8'h02) && (ACCEPT_REPLY != 0))))
                      code = ERR_OPER;
            default: code = ERR_NONE;
        endcase
        return code;
    endfunction

    // Lowest lane (lowest byte offset) with an error wins within a beat.
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_beat_err = ERR_NONE;
        for (int i = 0; i < BPB; i++) begin
            if (w_beat_err == ERR_NONE) begin
                w_beat_err = byte_err(w_off[i], w_byte[i]);
            end
        end
    end

`ifdef ARP_TPA_FILTER_EN
    // TPA is compared once the whole address is known, i.e. in the beat that
    // carries byte 27. Bytes 24..26 may already sit in the field registers.
    logic [31:0] w_tpa_next;
    logic        w_has_b27;

    always_comb begin
        w_tpa_next = tpa;
        w_has_b27  = 1'b0;
        for (int i = 0; i < BPB; i++) begin
            case (w_off[i])
                5'd24: w_tpa_next[31:24] = w_byte[i];
                5'd25: w_tpa_next[23:16] = w_byte[i];
                5'd26: w_tpa_next[15:8]  = w_byte[i];
                5'd27: begin
                    w_tpa_next[7:0] = w_byte[i];
                    w_has_b27       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_frame_err = ((w_beat_err == ERR_NONE) && w_has_b27 &&
                          (w_tpa_next != local_ip)) ? ERR_TPA : w_beat_err;
`else
    logic w_unused_local_ip;
    assign w_unused_local_ip = ^local_ip;
    assign w_frame_err       = w_beat_err;
`endif

    // The first error of the frame sticks; later ones are ignored.
    assign w_err_now = (r_err != ERR_NONE) ? r_err : w_frame_err;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bcnt      <= 5'd0;
            r_err       <= ERR_NONE;
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_NONE;

            case (r_state)
                S_IDLE, S_HDR, S_DRAIN: begin
                    if (w_take) begin
                        if (s_last) begin
                            // Frame ends: counter and error flag restart so
                            // IDLE sees the next beat as byte 0.
                            r_bcnt <= 5'd0;
                            r_err  <= ERR_NONE;
                            if (!w_full_next) begin
                                r_err_pulse <= 1'b1;
                                r_err_code  <= ERR_TRUNC;
                                r_state     <= S_IDLE;
                            end else if (w_err_now != ERR_NONE) begin
                                r_err_pulse <= 1'b1;
                                r_err_code  <= w_err_now;
                                r_state     <= S_IDLE;
                            end else begin
                                r_state <= S_HOLD;
                            end
                        end else begin
                            r_bcnt  <= w_bcnt_next;
                            r_err   <= w_err_now;
                            r_state <= w_full_next ? S_DRAIN : S_HDR;
                        end
                    end
                end
                S_HOLD: begin
                    if (m_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Field capture. Only beats accepted while collecting write fields, so the
    // outputs cannot change in HOLD (s_ready is low there anyway).
    // -------------------------------------------------------------------------
    // NOTE: this small array is reset, unlike a RAM, because its contents
    // drive the field outputs directly and those must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 6; k <= 27; k++) begin
                r_fld[k] <= 8'h00;
            end
        end else if (w_take && w_collect) begin
            for (int i = 0; i < BPB; i++) begin
                if ((w_off[i] >= 5'd6) && (w_off[i] <= 5'd27)) begin
                    r_fld[w_off[i]] <= w_byte[i];
                end
            end
        end
    end

    assign oper = {r_fld[6],  r_fld[7]};
    assign sha  = {r_fld[8],  r_fld[9],  r_fld[10], r_fld[11], r_fld[12], r_fld[13]};
    assign spa  = {r_fld[14], r_fld[15], r_fld[16], r_fld[17]};
    assign tha  = {r_fld[18], r_fld[19], r_fld[20], r_fld[21], r_fld[22], r_fld[23]};
    assign tpa  = {r_fld[24], r_fld[25], r_fld[26], r_fld[27]};

    assign err_valid = r_err_pulse;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_arp_rx_parser.sv
// -----------------------------------------------------------------------------
// tb_arp_rx_parser
//
// Four parser instances: u_dut0 DATA_W=8, u_dut1 DATA_W=16, u_dut2 DATA_W=32
// (all ACCEPT_REPLY=0) and u_dut3 DATA_W=8 with ACCEPT_REPLY=1. Directed
// frames are driven one at a time; each stimulus pushes its hand-computed
// expected outcome into a scoreboard queue, and an independent monitor pops
// and compares whenever a DUT raises m_valid or err_valid.
// -----------------------------------------------------------------------------
module tb_arp_rx_parser;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_valid_a   [4];
    logic        s_ready_a   [4];
    logic        s_last_a    [4];
    logic        m_valid_a   [4];
    logic        m_ready_a   [4];
    logic [15:0] oper_a      [4];
    logic [47:0] sha_a       [4];
    logic [31:0] spa_a       [4];
    logic [47:0] tha_a       [4];
    logic [31:0] tpa_a       [4];
    logic        err_valid_a [4];
    logic [2:0]  err_code_a  [4];
    logic [7:0]  s_data0;
    logic [15:0] s_data1;
    logic [31:0] s_data2;
    logic [7:0]  s_data3;
    logic [31:0] local_ip;

    arp_rx_parser #(.DATA_W(8), .ACCEPT_REPLY(0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid_a[0]), .s_ready(s_ready_a[0]),
        .s_data(s_data0), .s_last(s_last_a[0]), .local_ip(local_ip),
        .m_valid(m_valid_a[0]), .m_ready(m_ready_a[0]), .oper(oper_a[0]),
        .sha(sha_a[0]), .spa(spa_a[0]), .tha(tha_a[0]), .tpa(tpa_a[0]),
        .err_valid(err_valid_a[0]), .err_code(err_code_a[0]));

    arp_rx_parser #(.DATA_W(16), .ACCEPT_REPLY(0)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid_a[1]), .s_ready(s_ready_a[1]),
        .s_data(s_data1), .s_last(s_last_a[1]), .local_ip(local_ip),
        .m_valid(m_valid_a[1]), .m_ready(m_ready_a[1]), .oper(oper_a[1]),
        .sha(sha_a[1]), .spa(spa_a[1]), .tha(tha_a[1]), .tpa(tpa_a[1]),
        .err_valid(err_valid_a[1]), .err_code(err_code_a[1]));

    arp_rx_parser #(.DATA_W(32), .ACCEPT_REPLY(0)) u_dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid_a[2]), .s_ready(s_ready_a[2]),
        .s_data(s_data2), .s_last(s_last_a[2]), .local_ip(local_ip),
        .m_valid(m_valid_a[2]), .m_ready(m_ready_a[2]), .oper(oper_a[2]),
        .sha(sha_a[2]), .spa(spa_a[2]), .tha(tha_a[2]), .tpa(tpa_a[2]),
        .err_valid(err_valid_a[2]), .err_code(err_code_a[2]));

    arp_rx_parser #(.DATA_W(8), .ACCEPT_REPLY(1)) u_dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid_a[3]), .s_ready(s_ready_a[3]),
        .s_data(s_data3), .s_last(s_last_a[3]), .local_ip(local_ip),
        .m_valid(m_valid_a[3]), .m_ready(m_ready_a[3]), .oper(oper_a[3]),
        .sha(sha_a[3]), .spa(spa_a[3]), .tha(tha_a[3]), .tpa(tpa_a[3]),
        .err_valid(err_valid_a[3]), .err_code(err_code_a[3]));

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        int          dut;
        bit          is_err;
        logic [2:0]  code;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_ok(input int d, input logic [15:0] op);
        exp_t e;
        e.dut = d; e.is_err = 1'b0; e.code = 3'd0; e.oper = op;
        e.sha = 48'h02_00_00_00_00_01; e.spa = 32'h0A000001;
        e.tha = 48'h0; e.tpa = 32'h0A000002;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input int d, input logic [2:0] c);
        exp_t e;
        e.dut = d; e.is_err = 1'b1; e.code = c; e.oper = '0;
        e.sha = '0; e.spa = '0; e.tha = '0; e.tpa = '0;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per result/error, and re-checks the held
    // fields against that same expectation on every HOLD cycle.
    initial begin
        bit   seen [4];
        exp_t cur  [4];
        exp_t e;
        for (int d = 0; d < 4; d++) seen[d] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int d = 0; d < 4; d++) seen[d] = 1'b0;
            end else begin
                for (int d = 0; d < 4; d++) begin
                    if (err_valid_a[d]) begin
                        if (exp_q.size() == 0) begin
                            check("exp_queue_nonempty_on_err", 64'(exp_q.size()), 64'd1);
                        end else begin
                            e = exp_q.pop_front();
                            check("err_dut", 64'(d), 64'(e.dut));
                            check("err_valid_vs_expected", 64'(err_valid_a[d]), 64'(e.is_err));
                            check("err_code", 64'(err_code_a[d]), 64'(e.code));
                        end
                    end
                    if (m_valid_a[d]) begin
                        check("hold_s_ready_low", 64'(s_ready_a[d]), 64'd0);
                        if (!seen[d]) begin
                            if (exp_q.size() == 0) begin
                                check("exp_queue_nonempty_on_result", 64'(exp_q.size()), 64'd1);
                            end else begin
                                cur[d]  = exp_q.pop_front();
                                seen[d] = 1'b1;
                                check("result_dut", 64'(d), 64'(cur[d].dut));
                                check("m_valid_vs_expected", 64'(m_valid_a[d]), 64'(!cur[d].is_err));
                            end
                        end
                        if (seen[d]) begin
                            check("oper", 64'(oper_a[d]), 64'(cur[d].oper));
                            check("sha",  64'(sha_a[d]),  64'(cur[d].sha));
                            check("spa",  64'(spa_a[d]),  64'(cur[d].spa));
                            check("tha",  64'(tha_a[d]),  64'(cur[d].tha));
                            check("tpa",  64'(tpa_a[d]),  64'(cur[d].tpa));
                        end
                    end else begin
                        seen[d] = 1'b0;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    logic [7:0] frm [64];

    task automatic build_base();
        logic [7:0] base [28];
        base = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                 8'h0A, 8'h00, 8'h00, 8'h01,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h0A, 8'h00, 8'h00, 8'h02};
        for (int i = 0; i < 64; i++) frm[i] = (i < 28) ? base[i] : 8'h00;
    endtask

    task automatic drive_data(input int d, input logic [31:0] w);
        case (d)
            0: s_data0 = w[31:24];
            1: s_data1 = w[31:16];
            2: s_data2 = w;
            default: s_data3 = w[31:24];
        endcase
    endtask

    task automatic send_frame(input int d, input int len, input bit gaps,
                              input bit with_last);
        int bpb, nbeats, idx, t;
        logic [31:0] w;
        bpb    = (d == 1) ? 2 : ((d == 2) ? 4 : 1);
        nbeats = (len + bpb - 1) / bpb;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && (b % 3 == 2)) begin
                @(negedge clk);
                s_valid_a[d] = 1'b0;
                s_last_a[d]  = 1'b0;
            end
            w = '0;
            for (int l = 0; l < 4; l++) begin
                idx = b * bpb + l;
                w = {w[23:0], ((l < bpb) && (idx < len)) ? frm[idx] : 8'h00};
            end
            @(negedge clk);
            drive_data(d, w);
            s_valid_a[d] = 1'b1;
            s_last_a[d]  = with_last && (b == nbeats - 1);
            t = 0;
            while (!s_ready_a[d] && (t < 50)) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) check("s_ready_timeout", 64'(s_ready_a[d]), 64'd1);
        end
        @(negedge clk);
        s_valid_a[d] = 1'b0;
        s_last_a[d]  = 1'b0;
        if (with_last) begin
            check("result_latency", 64'(m_valid_a[d] | err_valid_a[d]), 64'd1);
        end
    endtask

    // Hold m_ready low for five cycles of m_valid, then release.
    task automatic hold_release(input int d);
        int t;
        t = 0;
        while (!m_valid_a[d] && (t < 20)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("m_valid_timeout", 64'(m_valid_a[d]), 64'd1);
        repeat (4) @(negedge clk);
        m_ready_a[d] = 1'b1;
        @(negedge clk);
        check("release_m_valid", 64'(m_valid_a[d]), 64'd0);
        check("release_s_ready", 64'(s_ready_a[d]), 64'd1);
    endtask

    task automatic check_reset_state(input int d);
        check("rst_s_ready",   64'(s_ready_a[d]),   64'd1);
        check("rst_m_valid",   64'(m_valid_a[d]),   64'd0);
        check("rst_err_valid", 64'(err_valid_a[d]), 64'd0);
        check("rst_err_code",  64'(err_code_a[d]),  64'd0);
        check("rst_oper",      64'(oper_a[d]),      64'd0);
        check("rst_sha",       64'(sha_a[d]),       64'd0);
        check("rst_spa",       64'(spa_a[d]),       64'd0);
        check("rst_tha",       64'(tha_a[d]),       64'd0);
        check("rst_tpa",       64'(tpa_a[d]),       64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        local_ip = 32'h0A000002;
        s_data0 = '0; s_data1 = '0; s_data2 = '0; s_data3 = '0;
        for (int d = 0; d < 4; d++) begin
            s_valid_a[d] = 1'b0;
            s_last_a[d]  = 1'b0;
            m_ready_a[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) check_reset_state(d);

        // Clean request, 8-bit
        build_base();
        push_ok(0, 16'h0001);
        send_frame(0, 28, 1'b0, 1'b1);

        // Same frame with 18 padding bytes, gaps, and a stalled consumer
        m_ready_a[1] = 1'b0;
        push_ok(1, 16'h0001);
        send_frame(1, 46, 1'b1, 1'b1);
        hold_release(1);

        m_ready_a[2] = 1'b0;
        push_ok(2, 16'h0001);
        send_frame(2, 46, 1'b1, 1'b1);
        hold_release(2);

        // PTYPE 0x86DD
        build_base();
        frm[2] = 8'h86; frm[3] = 8'hDD;
        push_err(0, 3'd2);
        send_frame(0, 28, 1'b0, 1'b1);

        // HTYPE 0002 and HLEN 8: the first error (HTYPE) is kept
        build_base();
        frm[1] = 8'h02; frm[4] = 8'h08;
        push_err(0, 3'd1);
        send_frame(0, 28, 1'b1, 1'b1);

        // OPER 0002: rejected without ACCEPT_REPLY, accepted with it
        build_base();
        frm[7] = 8'h02;
        push_err(0, 3'd4);
        send_frame(0, 28, 1'b0, 1'b1);
        push_ok(3, 16'h0002);
        send_frame(3, 28, 1'b0, 1'b1);

        // OPER 0003 is never valid
        build_base();
        frm[7] = 8'h03;
        push_err(3, 3'd4);
        send_frame(3, 28, 1'b0, 1'b1);

        // Two errors in one 32-bit beat: HTYPE (byte 1) beats PTYPE (byte 2)
        build_base();
        frm[1] = 8'h02; frm[2] = 8'h09;
        push_err(2, 3'd1);
        send_frame(2, 28, 1'b0, 1'b1);

        // s_last on byte 20: truncated
        build_base();
        push_err(0, 3'd5);
        send_frame(0, 21, 1'b0, 1'b1);

        // Reset in the middle of a frame, then a clean frame
        build_base();
        frm[8] = 8'hAA; frm[9] = 8'hBB; frm[10] = 8'hCC; frm[11] = 8'hDD;
        send_frame(0, 12, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state(0);
        build_base();
        push_ok(0, 16'h0001);
        send_frame(0, 28, 1'b0, 1'b1);

        // TPA filtering against local_ip
        local_ip = 32'h0A000003;
`ifdef ARP_TPA_FILTER_EN
        push_err(0, 3'd6);
`else
        push_ok(0, 16'h0001);
`endif
        send_frame(0, 28, 1'b0, 1'b1);
        local_ip = 32'h0A000002;
        push_ok(0, 16'h0001);
        send_frame(0, 28, 1'b0, 1'b1);

        repeat (10) @(negedge clk);
        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
